// File: rtl/shufflenet_layer_sequencer.sv
// Stage -> kernel -> step scheduler for the ShuffleNet datapath: issues weight/feature-map
// strobes, flips the ping-pong BRAM select per stage and pulses result-ready at the end.
module shufflenet_layer_sequencer #(
  parameter int NUM_STAGES = 40,
  parameter int WLOAD_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       feature_map_ready,
  input  logic       stall,
  input  logic [6:0] stage_kernels,
  input  logic [6:0] stage_steps,
  output logic       read_kernel_enable,
  output logic       read_featuremap_enable,
  output logic       write_featuremap_enable,
  output logic [5:0] stage_count,
  output logic [5:0] stage_count_next,
  output logic [6:0] kernel_count,
  output logic [6:0] kernel_count_7bit_next,
  output logic [6:0] step_count,
  output logic       select_bramA,
  output logic       shuffleNet_Result_Ready,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_W  = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [5:0] LAST_STAGE = 6'(NUM_STAGES - 1);
  localparam logic [3:0] WLOAD_LAST = 4'(WLOAD_CYC - 1);

  logic [2:0] state_q,    state_d;
  logic [5:0] stage_q,    stage_d;
  logic [6:0] kernel_q,   kernel_d;
  logic [6:0] step_q,     step_d;
  logic [3:0] wcnt_q,     wcnt_d;
  logic       sel_q,      sel_d;
  logic       fmr_prev_q, fmr_prev_d;

  logic [6:0] eff_kernels;
  logic [6:0] eff_steps;
  logic [6:0] kernels_last;
  logic [6:0] steps_last;
  logic       start;

  // A zero-sized stage from the LUT is run as a single kernel of a single step.
  assign eff_kernels  = (stage_kernels == 7'd0) ? 7'd1 : stage_kernels;
  assign eff_steps    = (stage_steps == 7'd0) ? 7'd1 : stage_steps;
  assign kernels_last = eff_kernels - 7'd1;
  assign steps_last   = eff_steps - 7'd1;
  assign start        = feature_map_ready && !fmr_prev_q;

  // NOTE: every _d gets its hold value first so no path through the case leaves one
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    kernel_d   = kernel_q;
    step_d     = step_q;
    wcnt_d     = wcnt_q;
    sel_d      = sel_q;
    fmr_prev_d = feature_map_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD_W;
          stage_d  = '0;
          kernel_d = '0;
          step_d   = '0;
          wcnt_d   = '0;
        end
      end

      ST_LOAD_W: begin
        if (!stall) begin
          if (wcnt_q >= WLOAD_LAST) begin
            wcnt_d  = '0;
            step_d  = '0;
            state_d = ST_COMPUTE;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end

      ST_COMPUTE: begin
        // Terminal compare before increment keeps step_count from ever wrapping.
        if (!stall) begin
          if (step_q >= steps_last) begin
            state_d = ST_WRITE;
          end else begin
            step_d = step_q + 7'd1;
          end
        end
      end

      ST_WRITE: begin
        if (!stall) begin
          if (kernel_q < kernels_last) begin
            kernel_d = kernel_q + 7'd1;
            step_d   = '0;
            wcnt_d   = '0;
            state_d  = ST_LOAD_W;
          end else if (stage_q < LAST_STAGE) begin
            stage_d  = stage_q + 6'd1;
            kernel_d = '0;
            step_d   = '0;
            wcnt_d   = '0;
            sel_d    = !sel_q;
            state_d  = ST_LOAD_W;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d  = ST_IDLE;
        stage_d  = '0;
        kernel_d = '0;
        step_d   = '0;
        wcnt_d   = '0;
        sel_d    = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        stage_d  = '0;
        kernel_d = '0;
        step_d   = '0;
        wcnt_d   = '0;
        sel_d    = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      kernel_q   <= '0;
      step_q     <= '0;
      wcnt_q     <= '0;
      sel_q      <= 1'b0;
      fmr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      kernel_q   <= kernel_d;
      step_q     <= step_d;
      wcnt_q     <= wcnt_d;
      sel_q      <= sel_d;
      fmr_prev_q <= fmr_prev_d;
    end
  end

  // Moore strobes decoded straight from the state register: mutually exclusive by construction.
  assign read_kernel_enable      = (state_q == ST_LOAD_W);
  assign read_featuremap_enable  = (state_q == ST_COMPUTE);
  assign write_featuremap_enable = (state_q == ST_WRITE);
  assign shuffleNet_Result_Ready = (state_q == ST_DONE);
  assign busy                    = (state_q != ST_IDLE);

  assign stage_count  = stage_q;
  assign kernel_count = kernel_q;
  assign step_count   = step_q;
  assign select_bramA = sel_q;

  // Look-ahead values must also reflect a reset about to be taken at this edge.
  assign stage_count_next       = reset ? 6'd0 : stage_d;
  assign kernel_count_7bit_next = reset ? 7'd0 : kernel_d;

endmodule

// File: tb/tb_shufflenet_layer_sequencer.sv
// Randomized bench for shufflenet_layer_sequencer: an expected per-cycle schedule is built
// from the stage table and consumed one entry per non-stalled cycle.
module tb_shufflenet_layer_sequencer;

  localparam int NS = 2;
  localparam int WL = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       feature_map_ready;
  logic       stall;
  logic [6:0] stage_kernels;
  logic [6:0] stage_steps;
  logic       read_kernel_enable;
  logic       read_featuremap_enable;
  logic       write_featuremap_enable;
  logic [5:0] stage_count;
  logic [5:0] stage_count_next;
  logic [6:0] kernel_count;
  logic [6:0] kernel_count_7bit_next;
  logic [6:0] step_count;
  logic       select_bramA;
  logic       shuffleNet_Result_Ready;
  logic       busy;

  shufflenet_layer_sequencer #(.NUM_STAGES(NS), .WLOAD_CYC(WL)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .feature_map_ready       (feature_map_ready),
    .stall                   (stall),
    .stage_kernels           (stage_kernels),
    .stage_steps             (stage_steps),
    .read_kernel_enable      (read_kernel_enable),
    .read_featuremap_enable  (read_featuremap_enable),
    .write_featuremap_enable (write_featuremap_enable),
    .stage_count             (stage_count),
    .stage_count_next        (stage_count_next),
    .kernel_count            (kernel_count),
    .kernel_count_7bit_next  (kernel_count_7bit_next),
    .step_count              (step_count),
    .select_bramA            (select_bramA),
    .shuffleNet_Result_Ready (shuffleNet_Result_Ready),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  // Stage table, looked up combinationally from the current stage.
  logic [6:0] k_lut [NS];
  logic [6:0] s_lut [NS];

  always_comb begin
    stage_kernels = '0;
    stage_steps   = '0;
    for (int i = 0; i < NS; i++) begin
      if (stage_count == 6'(i)) begin
        stage_kernels = k_lut[i];
        stage_steps   = s_lut[i];
      end
    end
  end

  typedef enum int {PH_LOAD, PH_COMP, PH_WRITE, PH_DONE} ph_e;
  typedef struct {
    ph_e ph;
    int  stg;
    int  ker;
    int  stp;
    bit  sel;
  } ent_t;

  ent_t q[$];
  bit   m_prev;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr, n_busy, n_rr, n_tog;
  bit   prev_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff(input logic [6:0] v);
    return (v == 7'd0) ? 1 : int'(v);
  endfunction

  // Whole-inference schedule: one entry per cycle the design should spend there without stall.
  task automatic build();
    int ek, es;
    q.delete();
    for (int s = 0; s < NS; s++) begin
      ek = eff(k_lut[s]);
      es = eff(s_lut[s]);
      for (int k = 0; k < ek; k++) begin
        for (int w = 0; w < WL; w++) q.push_back('{PH_LOAD, s, k, 0, bit'(s % 2)});
        for (int i = 0; i < es; i++) q.push_back('{PH_COMP, s, k, i, bit'(s % 2)});
        q.push_back('{PH_WRITE, s, k, es - 1, bit'(s % 2)});
      end
    end
    q.push_back('{PH_DONE, NS - 1, eff(k_lut[NS-1]) - 1, eff(s_lut[NS-1]) - 1, bit'((NS - 1) % 2)});
  endtask

  function automatic int base_cycles();
    int t = 1;
    for (int s = 0; s < NS; s++) t += eff(k_lut[s]) * (WL + eff(s_lut[s]) + 1);
    return t;
  endfunction

  task automatic check_next();
    int ns = 0, nk = 0;
    if (!reset && q.size() > 0 && q[0].ph != PH_DONE) begin
      if (stall) begin
        ns = q[0].stg; nk = q[0].ker;
      end else begin
        ns = q[1].stg; nk = q[1].ker;
      end
    end
    check("stage_next", 32'(stage_count_next), 32'(ns));
    check("kernel_next", 32'(kernel_count_7bit_next), 32'(nk));
  endtask

  task automatic advance();
    if (reset) begin
      q.delete();
      m_prev = 1'b0;
    end else begin
      if (q.size() == 0) begin
        if (feature_map_ready && !m_prev) build();
      end else if (q[0].ph == PH_DONE || !stall) begin
        void'(q.pop_front());
      end
      m_prev = feature_map_ready;
    end
  endtask

  task automatic check_regs();
    logic [4:0] en_e = '0;
    ent_t e = '{PH_LOAD, 0, 0, 0, 1'b0};
    if (q.size() > 0) begin
      e = q[0];
      case (e.ph)
        PH_LOAD:  en_e = 5'b10001;
        PH_COMP:  en_e = 5'b01001;
        PH_WRITE: en_e = 5'b00101;
        default:  en_e = 5'b00011;
      endcase
    end
    check("enables", 32'({read_kernel_enable, read_featuremap_enable, write_featuremap_enable,
                          shuffleNet_Result_Ready, busy}), 32'(en_e));
    check("stage", 32'(stage_count), 32'(e.stg));
    check("kernel", 32'(kernel_count), 32'(e.ker));
    check("step", 32'(step_count), 32'(e.stp));
    check("select", 32'(select_bramA), 32'(e.sel));
  endtask

  task automatic tick();
    #1;
    check_next();
    @(posedge clk);
    advance();
    #1;
    check_regs();
    if (write_featuremap_enable) n_wr++;
    if (busy && !shuffleNet_Result_Ready) n_busy++;
    if (shuffleNet_Result_Ready) n_rr++;
    if (busy && select_bramA != prev_sel) n_tog++;
    prev_sel = select_bramA;
  endtask

  task automatic do_run(input int stall_pct, input bit inject5, output int busy_cyc);
    int budget = 0;
    int injected = 0;
    n_wr = 0; n_busy = 0; n_rr = 0; n_tog = 0;
    prev_sel = select_bramA;
    feature_map_ready = 1'b1;
    stall = 1'b0;
    tick();
    while (q.size() > 0 && budget < 3000) begin
      if (inject5 && injected < 5 && q[0].ph == PH_COMP && q[0].stp == 1) begin
        stall = 1'b1;
        injected++;
      end else begin
        stall = ($urandom_range(99) < stall_pct);
      end
      tick();
      budget++;
    end
    stall = 1'b0;
    check("run_timeout", 32'(q.size()), 32'd0);
    busy_cyc = n_busy + n_rr;
  endtask

  task automatic set_lut(input int k, input int s);
    for (int i = 0; i < NS; i++) begin
      k_lut[i] = 7'(k);
      s_lut[i] = 7'(s);
    end
  endtask

  initial begin
    int bc, budget;
    reset = 1'b1;
    feature_map_ready = 1'b0;
    stall = 1'b0;
    m_prev = 1'b0;
    set_lut(2, 3);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Directed: 2 stages x 2 kernels x 3 steps, no stall.
    do_run(0, 1'b0, bc);
    check("write_strobes", 32'(n_wr), 32'd4);
    check("busy_to_last_write", 32'(n_busy), 32'd24);
    check("result_pulses", 32'(n_rr), 32'd1);
    check("select_toggles", 32'(n_tog), 32'd1);
    // Level held high after DONE must not restart.
    repeat (4) tick();
    check("no_restart_busy", 32'(busy), 32'd0);
    feature_map_ready = 1'b0;
    tick();

    // Five-cycle stall inside COMPUTE at step 1.
    do_run(0, 1'b1, bc);
    check("stall_delay", 32'(bc), 32'(base_cycles() + 5));
    feature_map_ready = 1'b0;
    tick();

    // Zero-sized stage table entries behave as 1.
    set_lut(0, 0);
    do_run(0, 1'b0, bc);
    check("zero_lut_cycles", 32'(bc), 32'(NS * (WL + 2) + 1));
    check("zero_lut_writes", 32'(n_wr), 32'(NS));
    feature_map_ready = 1'b0;
    tick();

    // Reset held 3 cycles mid-COMPUTE aborts the run.
    set_lut(2, 3);
    feature_map_ready = 1'b1;
    tick();
    budget = 0;
    while (!(q.size() > 0 && q[0].ph == PH_COMP && q[0].stp == 1) && budget < 100) begin
      tick();
      budget++;
    end
    check("reach_compute", 32'(budget < 100), 32'd1);
    reset = 1'b1;
    feature_map_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    n_wr = 0;
    repeat (3) tick();
    check("post_reset_writes", 32'(n_wr), 32'd0);

    // Randomized stage tables and stall patterns.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NS; i++) begin
        k_lut[i] = 7'($urandom_range(5));
        s_lut[i] = 7'($urandom_range(6));
      end
      do_run(30, 1'b0, bc);
      feature_map_ready = 1'b0;
      repeat (1 + $urandom_range(2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
